// File: rtl/acl_movement_reader_if.sv
// ADXL362 SPI pins plus the packed movement word handed to the sprite stage.
// The master modport is the reader; the slave modport is the sensor/consumer side.
interface acl_movement_reader_if;
  logic       ACL_MISO;
  logic       ACL_MOSI;
  logic       ACL_SCLK;
  logic       ACL_CSN;
  logic [9:0] movementData;
  logic       data_valid;
  logic       cfg_done;

  modport master (
    input  ACL_MISO,
    output ACL_MOSI, ACL_SCLK, ACL_CSN, movementData, data_valid, cfg_done
  );

  modport slave (
    output ACL_MISO,
    input  ACL_MOSI, ACL_SCLK, ACL_CSN, movementData, data_valid, cfg_done
  );
endinterface

// File: rtl/acl_movement_reader.sv
// ADXL362 SPI master: one POWER_CTL write after startup, then periodic X/Y burst reads
// scaled/saturated to 5 bits each. Optional deadzone via ACL_DEADZONE_EN. No backpressure.
module acl_movement_reader #(
  parameter int SCLK_DIV       = 50,
  parameter int STARTUP_CYCLES = 1000000,
  parameter int UPDATE_CYCLES  = 1666666,
  parameter int SHIFT          = 2,
  parameter int DEADZONE       = 1
) (
  input  logic                   CLK100MHZ,
  input  logic                   CPU_RESETN,
  acl_movement_reader_if.master  acl
);

  typedef enum logic [2:0] {
    ST_STARTUP, ST_CFG, ST_CFG_GAP, ST_READ, ST_UPDATE, ST_WAIT
  } state_t;

  localparam int          DIV_W      = $clog2(SCLK_DIV);
  localparam logic [31:0] CFG_FRAME  = 32'h0A2D_0200;
  localparam logic [31:0] READ_FRAME = 32'h0B08_0000;

  state_t            state, state_nxt;
  logic [31:0]       timer, timer_nxt;
  logic [DIV_W-1:0]  div_cnt, div_nxt;
  logic [6:0]        hp_cnt, hp_nxt;
  logic [31:0]       tx_sr, tx_nxt;
  logic [15:0]       rx_sr, rx_nxt;
  logic              csn, csn_nxt, sclk, sclk_nxt, mosi, mosi_nxt;
  logic [9:0]        mdata, mdata_nxt;
  logic              dv, dv_nxt, cfg_done, cfg_done_nxt;
  logic              tick, start;
  logic [31:0]       start_word;
  logic [6:0]        n2, k;

  // Scale one raw axis byte to 5-bit two's complement with saturation.
  function automatic logic [4:0] scale(input logic [7:0] raw);
    int s;
    s = int'($signed(raw)) >>> SHIFT;
    if (s > 15)
      s = 15;
    else if (s < -16)
      s = -16;
`ifdef ACL_DEADZONE_EN
    if (s <= DEADZONE && s >= -DEADZONE)
      s = 0;
`endif
    return 5'(s);
  endfunction

  assign tick = (div_cnt == DIV_W'(SCLK_DIV - 1));

  always_comb begin
    state_nxt    = state;
    timer_nxt    = (timer != '1) ? timer + 32'd1 : timer;
    div_nxt      = '0;
    hp_nxt       = hp_cnt;
    tx_nxt       = tx_sr;
    rx_nxt       = rx_sr;
    csn_nxt      = csn;
    sclk_nxt     = sclk;
    mosi_nxt     = mosi;
    mdata_nxt    = mdata;
    dv_nxt       = 1'b0;
    cfg_done_nxt = cfg_done;
    start        = 1'b0;
    start_word   = READ_FRAME;
    n2           = (state == ST_CFG) ? 7'd48 : 7'd64;
    k            = hp_cnt + 7'd1;

    if (state == ST_CFG || state == ST_CFG_GAP || state == ST_READ)
      div_nxt = tick ? '0 : div_cnt + DIV_W'(1);

    case (state)
      ST_STARTUP: begin
        if (timer == 32'(STARTUP_CYCLES - 1)) begin
          start      = 1'b1;
          start_word = CFG_FRAME;
          state_nxt  = ST_CFG;
        end
      end
      ST_CFG, ST_READ: begin
        if (tick) begin
          hp_nxt = k;
          // Odd half-periods are rising edges (sample), even ones falling (shift out).
          if (k <= n2) begin
            if (k[0]) begin
              sclk_nxt = 1'b1;
              rx_nxt   = {rx_sr[14:0], acl.ACL_MISO};
            end else begin
              sclk_nxt = 1'b0;
              if (k < n2) begin
                mosi_nxt = tx_sr[30];
                tx_nxt   = tx_sr << 1;
              end
            end
          end else if (k == n2 + 7'd1) begin
            csn_nxt  = 1'b1;
            mosi_nxt = 1'b0;
            if (state == ST_CFG) begin
              hp_nxt    = '0;
              state_nxt = ST_CFG_GAP;
            end
          end else if (k == n2 + 7'd3) begin
            state_nxt = ST_UPDATE;
          end
        end
      end
      ST_CFG_GAP: begin
        if (tick) begin
          hp_nxt = k;
          if (k == 7'd2) begin
            cfg_done_nxt = 1'b1;
            start        = 1'b1;
            timer_nxt    = '0;
            state_nxt    = ST_READ;
          end
        end
      end
      ST_UPDATE: begin
        mdata_nxt = {scale(rx_sr[15:8]), scale(rx_sr[7:0])};
        dv_nxt    = 1'b1;
        state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (timer >= 32'(UPDATE_CYCLES - 1)) begin
          start     = 1'b1;
          timer_nxt = '0;
          state_nxt = ST_READ;
        end
      end
      default: state_nxt = ST_STARTUP;
    endcase

    if (start) begin
      csn_nxt  = 1'b0;
      sclk_nxt = 1'b0;
      tx_nxt   = start_word;
      mosi_nxt = start_word[31];
      hp_nxt   = '0;
      div_nxt  = '0;
      rx_nxt   = '0;
    end
  end

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      state    <= ST_STARTUP;
      timer    <= '0;
      div_cnt  <= '0;
      hp_cnt   <= '0;
      tx_sr    <= '0;
      rx_sr    <= '0;
      csn      <= 1'b1;
      sclk     <= 1'b0;
      mosi     <= 1'b0;
      mdata    <= '0;
      dv       <= 1'b0;
      cfg_done <= 1'b0;
    end else begin
      state    <= state_nxt;
      timer    <= timer_nxt;
      div_cnt  <= div_nxt;
      hp_cnt   <= hp_nxt;
      tx_sr    <= tx_nxt;
      rx_sr    <= rx_nxt;
      csn      <= csn_nxt;
      sclk     <= sclk_nxt;
      mosi     <= mosi_nxt;
      mdata    <= mdata_nxt;
      dv       <= dv_nxt;
      cfg_done <= cfg_done_nxt;
    end
  end

  assign acl.ACL_CSN      = csn;
  assign acl.ACL_SCLK     = sclk;
  assign acl.ACL_MOSI     = mosi;
  assign acl.movementData = mdata;
  assign acl.data_valid   = dv;
  assign acl.cfg_done     = cfg_done;

endmodule
